// File: rtl/alu_pkg.sv
// alu_pkg: ALU control codes, main-control ALU classes, R-type funct values and the default op-bundle width.
package alu_pkg;
   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_NOR = 4'b1100;
   localparam logic [1:0] ALUOP_MEM   = 2'b00;
   localparam logic [1:0] ALUOP_BR    = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE = 2'b10;
   localparam logic [5:0] FUNCT_ADD = 6'b100000;
   localparam logic [5:0] FUNCT_SUB = 6'b100010;
   localparam logic [5:0] FUNCT_AND = 6'b100100;
   localparam logic [5:0] FUNCT_OR  = 6'b100101;
   localparam logic [5:0] FUNCT_SLT = 6'b101010;
   localparam logic [5:0] FUNCT_NOR = 6'b100111;
   // {ALUCont, A, B, dest, illegal} at the default widths
   localparam int OP_W = 4 + 32 + 32 + 5 + 1;
endpackage

// File: rtl/alu_decode.sv
// alu_decode: combinational ALU_Op/funct to ALUCont; unknown encodings execute as ADD and are flagged illegal.
module alu_decode
   import alu_pkg::*;
#(
   parameter int CONT_W = 4
) (
   input  logic [1:0]        alu_op,
   input  logic [5:0]        funct,
   output logic [CONT_W-1:0] cont,
   output logic              illegal
);
   logic [3:0] code;
   always_comb begin
      code    = ALU_ADD;
      illegal = 1'b0;
      case (alu_op)
         ALUOP_MEM: code = ALU_ADD;
         ALUOP_BR:  code = ALU_SUB;
         ALUOP_RTYPE:
            case (funct)
               FUNCT_ADD: code = ALU_ADD;
               FUNCT_SUB: code = ALU_SUB;
               FUNCT_AND: code = ALU_AND;
               FUNCT_OR:  code = ALU_OR;
               FUNCT_SLT: code = ALU_SLT;
               FUNCT_NOR: code = ALU_NOR;
               default:   illegal = 1'b1;
            endcase
         default: illegal = 1'b1;
      endcase
   end
   assign cont = CONT_W'(code);
endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: registered ID/EX issue stage with a one-entry skid behind the main register,
// valid/ready handshake to the ALU, flush, and a saturating illegal-op counter.
module alu_issue_stage
   import alu_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int CONT_W = 4,
   parameter int REG_W  = 5,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        ALU_Op,
   input  logic [5:0]        funct_field,
   input  logic [DATA_W-1:0] rs_data,
   input  logic [DATA_W-1:0] rt_data,
   input  logic [DATA_W-1:0] imm,
   input  logic              ALUSrc,
   input  logic [REG_W-1:0]  dest_reg,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CONT_W-1:0] ALUCont,
   output logic [DATA_W-1:0] A,
   output logic [DATA_W-1:0] B,
   output logic [REG_W-1:0]  out_dest,
   output logic              out_illegal,
   output logic [CNT_W-1:0]  illegal_cnt
);
   localparam int BW = CONT_W + 2 * DATA_W + REG_W + 1;
   logic [CONT_W-1:0] cont;
   logic              illegal;
   logic [BW-1:0]     in_op, main_op, skid_op;
   logic              skid_valid, accept, fire;

   alu_decode #(.CONT_W(CONT_W)) u_decode (
      .alu_op  (ALU_Op),
      .funct   (funct_field),
      .cont    (cont),
      .illegal (illegal)
   );

   assign in_op    = {cont, rs_data, ALUSrc ? imm : rt_data, dest_reg, illegal};
   assign in_ready = ~skid_valid;
   assign accept   = in_valid & in_ready & ~flush;
   assign fire     = out_valid & out_ready;
   assign {ALUCont, A, B, out_dest, out_illegal} = main_op;

   // skid is only ever occupied while main holds an unfired op, so main-empty implies skid-empty
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         skid_valid <= 1'b0;
         main_op    <= '0;
         skid_op    <= '0;
      end else if (flush) begin
         out_valid  <= 1'b0;
         skid_valid <= 1'b0;
      end else if (!out_valid || fire) begin
         if (skid_valid) begin
            main_op    <= skid_op;
            out_valid  <= 1'b1;
            skid_valid <= 1'b0;
         end else if (accept) begin
            main_op   <= in_op;
            out_valid <= 1'b1;
         end else begin
            out_valid <= 1'b0;
         end
      end else if (accept) begin
         skid_op    <= in_op;
         skid_valid <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) illegal_cnt <= '0;
      else if (accept && illegal && !(&illegal_cnt)) illegal_cnt <= illegal_cnt + 1'b1;
   end
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed vectors with hand-computed expectations for the ALU issue stage.
module tb_alu_issue_stage;
   logic        clk = 1'b0;
   logic        rst_n, flush, in_valid, in_ready, ALUSrc, out_valid, out_ready, out_illegal;
   logic [1:0]  ALU_Op;
   logic [5:0]  funct_field;
   logic [31:0] rs_data, rt_data, imm, A, B;
   logic [4:0]  dest_reg, out_dest;
   logic [3:0]  ALUCont;
   logic [7:0]  illegal_cnt;
   int          n_pass = 0, n_chk = 0;

   alu_issue_stage dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .ALU_Op(ALU_Op), .funct_field(funct_field), .rs_data(rs_data), .rt_data(rt_data),
      .imm(imm), .ALUSrc(ALUSrc), .dest_reg(dest_reg), .out_valid(out_valid),
      .out_ready(out_ready), .ALUCont(ALUCont), .A(A), .B(B), .out_dest(out_dest),
      .out_illegal(out_illegal), .illegal_cnt(illegal_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] op, input logic [5:0] fn, input logic [31:0] rs);
      in_valid = 1'b1; ALU_Op = op; funct_field = fn; rs_data = rs;
   endtask

   logic [5:0] fn_tab [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27};
   logic [3:0] cd_tab [6] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111, 4'b1100};

   initial begin
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; ALUSrc = 1'b0;
      ALU_Op = 2'b00; funct_field = 6'h0; rs_data = '0; rt_data = '0; imm = '0; dest_reg = '0;
      #12;
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_alucont", ALUCont, 0);
      check("rst_a", A, 0);
      check("rst_b", B, 0);
      check("rst_cnt", illegal_cnt, 0);
      rst_n = 1'b1;
      tick();
      drive(2'b10, 6'b100010, 32'h22222222); rt_data = 32'h11111111; dest_reg = 5'd7;
      tick();
      check("sub_valid", out_valid, 1);
      check("sub_cont", ALUCont, 4'b0110);
      check("sub_a", A, 32'h22222222);
      check("sub_b", B, 32'h11111111);
      check("sub_dest", out_dest, 7);
      drive(2'b00, 6'h0, 32'h5); imm = 32'h4; ALUSrc = 1'b1;
      tick();
      check("mem_cont", ALUCont, 4'b0010);
      check("mem_b", B, 32'h4);
      ALU_Op = 2'b01;
      tick();
      check("br_cont", ALUCont, 4'b0110);
      ALUSrc = 1'b0;
      for (int i = 0; i < 6; i++) begin
         drive(2'b10, fn_tab[i], 32'h100 + i);
         tick();
         check($sformatf("funct_%0h_cont", fn_tab[i]), ALUCont, cd_tab[i]);
         check($sformatf("funct_%0h_ill", fn_tab[i]), out_illegal, 0);
      end
      drive(2'b10, 6'h21, 32'h0);
      tick();
      check("badfunct_cont", ALUCont, 4'b0010);
      check("badfunct_ill", out_illegal, 1);
      drive(2'b11, 6'h20, 32'h0);
      tick();
      check("op11_ill", out_illegal, 1);
      check("cnt_two", illegal_cnt, 2);
      in_valid = 1'b0;
      tick();
      check("drain_valid", out_valid, 0);
      check("drain_hold", ALUCont, 4'b0010);
      // stall: X held, Y in skid, Z waits, then drain in order
      out_ready = 1'b0;
      drive(2'b00, 6'h0, 32'h1);
      tick();
      check("x_in_ready", in_ready, 1);
      drive(2'b00, 6'h0, 32'h2);
      tick();
      check("y_in_ready", in_ready, 0);
      check("y_a_holds_x", A, 32'h1);
      drive(2'b00, 6'h0, 32'h3);
      tick();
      check("z_stall_ready", in_ready, 0);
      check("z_stall_valid", out_valid, 1);
      check("z_stall_a", A, 32'h1);
      out_ready = 1'b1;
      tick();
      check("order_y", A, 32'h2);
      check("order_y_ready", in_ready, 1);
      tick();
      check("order_z", A, 32'h3);
      in_valid = 1'b0;
      tick();
      check("order_empty", out_valid, 0);
      // flush with main and skid full
      out_ready = 1'b0;
      drive(2'b00, 6'h0, 32'hA1);
      tick();
      drive(2'b00, 6'h0, 32'hA2);
      tick();
      check("fl_full", in_ready, 0);
      drive(2'b00, 6'h0, 32'hA3); flush = 1'b1;
      tick();
      check("fl_valid", out_valid, 0);
      check("fl_ready", in_ready, 1);
      check("fl_hold_a", A, 32'hA1);
      // flush drops an illegal op offered while ready
      out_ready = 1'b1;
      drive(2'b11, 6'h0, 32'hA4);
      tick();
      check("fl_drop_valid", out_valid, 0);
      check("fl_drop_cnt", illegal_cnt, 2);
      flush = 1'b0; in_valid = 1'b0;
      tick();
      drive(2'b10, 6'h3F, 32'h0);
      tick();
      check("sat_first_cont", ALUCont, 4'b0010);
      check("sat_first_ill", out_illegal, 1);
      check("sat_first_cnt", illegal_cnt, 3);
      for (int i = 1; i < 300; i++) tick();
      check("sat_cnt", illegal_cnt, 8'hFF);
      in_valid = 1'b0;
      tick();
      // async reset while stalled with skid full
      out_ready = 1'b0;
      drive(2'b00, 6'h0, 32'hB1); dest_reg = 5'd9;
      tick();
      drive(2'b00, 6'h0, 32'hB2);
      tick();
      check("rs_full", in_ready, 0);
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("rs_valid", out_valid, 0);
      check("rs_ready", in_ready, 1);
      check("rs_a", A, 0);
      check("rs_dest", out_dest, 0);
      check("rs_cnt", illegal_cnt, 0);
      tick();
      rst_n = 1'b1;
      out_ready = 1'b1;
      drive(2'b00, 6'h0, 32'hC1);
      tick();
      check("post_valid", out_valid, 1);
      check("post_a", A, 32'hC1);
      in_valid = 1'b0;
      tick();
      check("post_empty", out_valid, 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
